// File: rtl/axi_lite_master_ctrl_pkg.sv
// Shared types and constants for the AXI4-Lite master sequencer.
package axi_lite_master_ctrl_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Sequencer states: one request and one response phase per direction
  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } ctrl_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 256;

  function automatic logic is_wr_state(ctrl_state_t s);
    return (s == WR_REQ) || (s == WR_RESP);
  endfunction

endpackage

// File: rtl/axi_lite_master_ctrl_wr_issue.sv
// AW/W issue: both channels raise valid together and each drops on its
// own handshake; both_done flags the edge at which the later one completes.
module axi_lite_wr_issue (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic awready_i,
  input  logic wready_i,
  output logic awvalid_o,
  output logic wvalid_o,
  output logic aw_hs_o,
  output logic w_hs_o,
  output logic both_done_o
);

  logic aw_done_q, w_done_q;

  assign awvalid_o   = active_i & ~aw_done_q;
  assign wvalid_o    = active_i & ~w_done_q;
  assign aw_hs_o     = awvalid_o & awready_i;
  assign w_hs_o      = wvalid_o & wready_i;
  assign both_done_o = active_i & (aw_done_q | aw_hs_o) & (w_done_q | w_hs_o);

  // Per-channel acceptance flags, cleared whenever the write phase ends
  always_ff @(posedge clk_i) begin
    if (rst_i || !active_i || both_done_o) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs_o) aw_done_q <= 1'b1;
      if (w_hs_o)  w_done_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_master_ctrl.sv
// AXI4-Lite master sequencer: turns start pulses into full AW/W/B or AR/R
// transactions; a simultaneous read+write runs back to back, ordered by
// which direction completed last. Optional watchdog: AXI_CTRL_TIMEOUT_EN.
module axi_lite_master_ctrl
  import axi_lite_master_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                aclk_i,
  input  logic                areset_i,
  input  logic                start_read_i,
  input  logic                start_write_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                done_is_wr_o,
  output logic [1:0]          resp_o,
  output logic [DATA_W-1:0]   rd_data_o,
`ifdef AXI_CTRL_TIMEOUT_EN
  output logic                timeout_err_o,
`endif
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rvalid_i,
  output logic                rready_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  ctrl_state_t       state_q, state_d;
  logic              pending_q, pending_d;
  logic              last_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rd_data_q;
  logic [1:0]        resp_q;
  logic              done_q, done_is_wr_q;

  logic wr_active, aw_hs, w_hs, wr_both_done;
  logic wr_cmpl, rd_cmpl, start_any, tmo;

  assign wr_active = (state_q == WR_REQ);
  assign wr_cmpl   = (state_q == WR_RESP) && bvalid_i;
  assign rd_cmpl   = (state_q == RD_RESP) && rvalid_i;
  assign start_any = (state_q == IDLE) && (start_read_i || start_write_i);

  axi_lite_wr_issue u_wr_issue (
    .clk_i       (aclk_i),
    .rst_i       (areset_i),
    .active_i    (wr_active),
    .awready_i   (awready_i),
    .wready_i    (wready_i),
    .awvalid_o   (awvalid_o),
    .wvalid_o    (wvalid_o),
    .aw_hs_o     (aw_hs),
    .w_hs_o      (w_hs),
    .both_done_o (wr_both_done)
  );

`ifdef AXI_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, any_hs;

  assign any_hs = aw_hs | w_hs | wr_cmpl | (arvalid_o & arready_i) | rd_cmpl;
  assign tmo    = (state_q != IDLE) && !any_hs &&
                  (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on any handshake and idles at zero
  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (state_q == IDLE || any_hs || tmo) tmo_cnt_d = '0;
  end

  // Watchdog counter and error flag registers
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= tmo;
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next state: a paired request skips IDLE and jumps to the other REQ
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (start_write_i && start_read_i) begin
          pending_d = 1'b1;
          state_d   = last_wr_q ? RD_REQ : WR_REQ;
        end else if (start_write_i) begin
          state_d = WR_REQ;
        end else if (start_read_i) begin
          state_d = RD_REQ;
        end
      end
      WR_REQ:  if (wr_both_done) state_d = WR_RESP;
      WR_RESP: if (bvalid_i) begin
        pending_d = 1'b0;
        state_d   = pending_q ? RD_REQ : IDLE;
      end
      RD_REQ:  if (arready_i) state_d = RD_RESP;
      RD_RESP: if (rvalid_i) begin
        pending_d = 1'b0;
        state_d   = pending_q ? WR_REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d   = IDLE;
      pending_d = 1'b0;
    end
  end

  // State-decoded channel controls (AW/W valids come from the issue unit)
  always_comb begin
    busy_o    = (state_q != IDLE);
    bready_o  = (state_q == WR_RESP);
    arvalid_o = (state_q == RD_REQ);
    rready_o  = (state_q == RD_RESP);
  end

  // Request capture, completion reporting and arbitration history
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      addr_q       <= '0;
      data_q       <= '0;
      rd_data_q    <= '0;
      resp_q       <= '0;
      done_q       <= 1'b0;
      done_is_wr_q <= 1'b0;
      last_wr_q    <= 1'b0;
    end else begin
      done_q <= wr_cmpl | rd_cmpl | tmo;
      if (start_any) begin
        addr_q <= addr_i;
        if (start_write_i) data_q <= data_i;
      end
      if (wr_cmpl) begin
        resp_q       <= bresp_i;
        done_is_wr_q <= 1'b1;
        last_wr_q    <= 1'b1;
      end else if (rd_cmpl) begin
        resp_q       <= rresp_i;
        rd_data_q    <= rdata_i;
        done_is_wr_q <= 1'b0;
        last_wr_q    <= 1'b0;
      end else if (tmo) begin
        resp_q       <= RESP_SLVERR;
        done_is_wr_q <= is_wr_state(state_q);
        last_wr_q    <= is_wr_state(state_q);
      end
    end
  end

  assign done_o       = done_q;
  assign done_is_wr_o = done_is_wr_q;
  assign resp_o       = resp_q;
  assign rd_data_o    = rd_data_q;
  assign awaddr_o     = addr_q;
  assign araddr_o     = addr_q;
  assign wdata_o      = data_q;
  assign wstrb_o      = '1;

endmodule
